// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory-stage access unit (master) and the memory system (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [BYTES-1:0]  bus_byte_en;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit for the MEM stage: alignment check, lane steering,
// req/ack bus transaction with timeout, and sign/zero extension of load data.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              exc_valid,
    output logic [2:0]        exc_code,
    mem_access_unit_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [7:0]       count_reg;
    logic [OFS_W-1:0] ofs_reg;
    logic [1:0]       size_reg;
    logic             signed_reg;
    logic             we_reg;

    logic [OFS_W-1:0]  ofs;
    logic [3:0]        nbytes;
    logic              illegal;
    logic              aligned;
    logic [BYTES-1:0]  lane_en;
    logic [DATA_W-1:0] wdata_masked;
    logic [DATA_W-1:0] wdata_lane;

    assign ofs     = req_addr[OFS_W-1:0];
    assign nbytes  = 4'd1 << req_size;
    assign illegal = (DATA_W == 32) && (req_size == 2'd3);
    assign aligned = (ofs & OFS_W'(nbytes - 4'd1)) == '0;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_store_lane
            assign lane_en[gi] = (32'(gi) >= 32'(ofs)) && (32'(gi) < 32'(ofs) + 32'(nbytes));
            assign wdata_masked[8*gi +: 8] = (32'(gi) < 32'(nbytes)) ? req_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign wdata_lane = wdata_masked << {ofs, 3'b000};

    // Load path works from the latched offset/size, since req_* may change once stall drops.
    logic [3:0]        nbytes_lat;
    logic [DATA_W-1:0] rdata_shift;
    logic [DATA_W-1:0] rdata_ext;
    logic              sign_bit;

    assign nbytes_lat  = 4'd1 << size_reg;
    assign rdata_shift = bus.bus_rdata >> {ofs_reg, 3'b000};

    always_comb begin
        sign_bit = 1'b0;
        case (size_reg)
            2'd0:    sign_bit = rdata_shift[7];
            2'd1:    sign_bit = rdata_shift[15];
            2'd2:    sign_bit = rdata_shift[31];
            default: sign_bit = rdata_shift[DATA_W-1];
        endcase
        sign_bit = sign_bit & signed_reg;
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_load_lane
            assign rdata_ext[8*gi +: 8] = (32'(gi) < 32'(nbytes_lat)) ? rdata_shift[8*gi +: 8]
                                                                       : {8{sign_bit}};
        end
    endgenerate

    assign stall = (state_reg == IDLE) ? req_valid : (state_reg == BUSY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            ofs_reg         <= '0;
            size_reg        <= '0;
            signed_reg      <= 1'b0;
            we_reg          <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            exc_valid       <= 1'b0;
            exc_code        <= '0;
            bus.bus_req     <= 1'b0;
            bus.bus_we      <= 1'b0;
            bus.bus_addr    <= '0;
            bus.bus_byte_en <= '0;
            bus.bus_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            exc_valid  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    resp_rdata <= '0;
                    exc_code   <= '0;
                    if (req_valid) begin
                        ofs_reg    <= ofs;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        we_reg     <= req_we;
                        if (illegal || !aligned) begin
                            state_reg <= DONE;
                            exc_valid <= 1'b1;
                            exc_code  <= illegal ? 3'd5 : (req_we ? 3'd2 : 3'd1);
                        end else begin
                            state_reg       <= BUSY;
                            count_reg       <= '0;
                            bus.bus_req     <= 1'b1;
                            bus.bus_we      <= req_we;
                            bus.bus_addr    <= req_addr & ~ADDR_W'(BYTES - 1);
                            bus.bus_byte_en <= lane_en;
                            bus.bus_wdata   <= wdata_lane;
                        end
                    end
                end
                BUSY: begin
                    count_reg <= count_reg + 8'd1;
                    // An ack arriving on the last allowed cycle still completes normally.
                    if (bus.bus_ack || (count_reg == 8'(TIMEOUT - 1))) begin
                        state_reg       <= DONE;
                        bus.bus_req     <= 1'b0;
                        bus.bus_we      <= 1'b0;
                        bus.bus_addr    <= '0;
                        bus.bus_byte_en <= '0;
                        bus.bus_wdata   <= '0;
                        if (!bus.bus_ack) begin
                            exc_valid <= 1'b1;
                            exc_code  <= 3'd4;
                        end else if (bus.bus_err) begin
                            exc_valid <= 1'b1;
                            exc_code  <= 3'd3;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= we_reg ? '0 : rdata_ext;
                        end
                    end
                end
                DONE: begin
                    state_reg  <= IDLE;
                    resp_rdata <= '0;
                    exc_code   <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance (TIMEOUT=15)
// driven one at a time through a shared request/bus-slave model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        sel64;
    logic        ack, err;
    logic [63:0] rdata;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    logic        stall32, rv32, ev32, stall64, rv64, ev64;
    logic [31:0] rd32;
    logic [63:0] rd64;
    logic [2:0]  ec32, ec64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel64), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .stall(stall32), .resp_valid(rv32), .resp_rdata(rd32),
        .exc_valid(ev32), .exc_code(ec32), .bus(bus32)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) dut64 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel64), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall64), .resp_valid(rv64), .resp_rdata(rd64),
        .exc_valid(ev64), .exc_code(ec64), .bus(bus64)
    );

    assign bus32.bus_ack   = ack & ~sel64;
    assign bus32.bus_err   = err;
    assign bus32.bus_rdata = rdata[31:0];
    assign bus64.bus_ack   = ack & sel64;
    assign bus64.bus_err   = err;
    assign bus64.bus_rdata = rdata;

    logic        stall_m, rv_m, ev_m, breq_m, bwe_m;
    logic [2:0]  ec_m;
    logic [63:0] rd_m, bwd_m;
    logic [31:0] baddr_m;
    logic [7:0]  ben_m;

    assign stall_m = sel64 ? stall64 : stall32;
    assign rv_m    = sel64 ? rv64 : rv32;
    assign ev_m    = sel64 ? ev64 : ev32;
    assign ec_m    = sel64 ? ec64 : ec32;
    assign rd_m    = sel64 ? rd64 : {32'h0, rd32};
    assign breq_m  = sel64 ? bus64.bus_req : bus32.bus_req;
    assign bwe_m   = sel64 ? bus64.bus_we : bus32.bus_we;
    assign baddr_m = sel64 ? bus64.bus_addr : bus32.bus_addr;
    assign ben_m   = sel64 ? bus64.bus_byte_en : {4'h0, bus32.bus_byte_en};
    assign bwd_m   = sel64 ? bus64.bus_wdata : {32'h0, bus32.bus_wdata};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-by-byte view of the access, derived from the rules, not the RTL structure.
    function automatic void model(input bit is64, input bit we, input bit [1:0] size, input bit sgn,
                                  input bit [31:0] addr, input bit [63:0] wdata, input bit [63:0] rd,
                                  input int delay, input bit berr,
                                  output bit [7:0] be, output bit [63:0] bwd, output bit [63:0] res,
                                  output bit [2:0] code, output int stall_cycles);
        int nb, n, ofs, tmo;
        nb  = is64 ? 8 : 4;
        tmo = is64 ? 15 : 4;
        n   = 1 << size;
        ofs = int'(addr) % nb;
        be = '0; bwd = '0; res = '0; code = '0;
        for (int i = 0; i < n && ofs + i < nb; i++) begin
            be[ofs+i] = 1'b1;
            bwd[8*(ofs+i) +: 8] = wdata[8*i +: 8];
        end
        if (!is64 && size == 2'd3) begin
            code = 3'd5; stall_cycles = 1;
        end else if (ofs % n != 0) begin
            code = we ? 3'd2 : 3'd1; stall_cycles = 1;
        end else if (delay >= tmo) begin
            code = 3'd4; stall_cycles = 1 + tmo;
        end else begin
            stall_cycles = 2 + delay;
            if (berr) code = 3'd3;
            else if (!we) begin
                for (int i = 0; i < n; i++) res[8*i +: 8] = rd[8*(ofs+i) +: 8];
                if (sgn && res[8*n-1])
                    for (int i = n; i < 8; i++) res[8*i +: 8] = 8'hFF;
                if (!is64) res[63:32] = '0;
            end
        end
    endfunction

    task automatic run_txn(input string tag, input bit is64, input bit we, input bit [1:0] size,
                           input bit sgn, input bit [31:0] addr, input bit [63:0] wdata,
                           input bit [63:0] rd, input int delay, input bit berr,
                           input bit [7:0] e_be, input bit [63:0] e_bwd, input bit [63:0] e_res,
                           input bit [2:0] e_code, input int e_stall);
        int stalls, reqs, cyc;
        bit done, bus_ok, got_rv, got_ev;
        bit [2:0] got_code;
        bit [63:0] got_rd;
        bit [31:0] e_addr;
        stalls = 0; reqs = 0; cyc = 0; done = 0; bus_ok = 1;
        got_rv = 0; got_ev = 0; got_code = '0; got_rd = '0;
        e_addr = addr & ~(is64 ? 32'h7 : 32'h3);
        @(negedge clk);
        sel64 = is64; req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
        req_wdata = wdata; rdata = rd; err = berr; ack = 1'b0; req_valid = 1'b1;
        #1;
        if (stall_m) stalls++;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rv_m || ev_m) begin
                done = 1; got_rv = rv_m; got_ev = ev_m; got_code = ec_m; got_rd = rd_m;
                ack = 1'b0;
                chk({tag, "_stall_done"}, 64'(stall_m), 64'(0));
            end else begin
                if (stall_m) stalls++;
                if (breq_m) begin
                    reqs++;
                    if (bwe_m !== we || baddr_m !== e_addr || ben_m !== e_be || bwd_m !== e_bwd)
                        bus_ok = 0;
                    ack = (reqs == delay + 1);
                end else begin
                    ack = 1'b0;
                end
            end
        end
        chk({tag, "_completed"}, 64'(done), 64'(1));
        chk({tag, "_resp_valid"}, 64'(got_rv), 64'(e_code == 3'd0));
        chk({tag, "_exc_valid"}, 64'(got_ev), 64'(e_code != 3'd0));
        chk({tag, "_exc_code"}, 64'(got_code), 64'(e_code));
        if (e_code == 3'd0) chk({tag, "_rdata"}, got_rd, e_res);
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(e_stall));
        chk({tag, "_bus_req_cycles"}, 64'(reqs), 64'(e_stall - 1));
        chk({tag, "_bus_fields"}, 64'(bus_ok), 64'(1));
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_width"}, 64'(rv_m | ev_m | breq_m), 64'(0));
        $display("txn %s dut%0d we=%0d size=%0d addr=%h code=%0d rdata=%h stall=%0d",
                 tag, is64 ? 64 : 32, we, size, addr, got_code, got_rd, stalls);
    endtask

    typedef struct {
        bit        is64;
        bit        we;
        bit [1:0]  size;
        bit        sgn;
        bit [31:0] addr;
        bit [63:0] wdata;
        bit [63:0] rd;
        int        delay;
        bit        berr;
        bit [7:0]  e_be;
        bit [63:0] e_bwd;
        bit [63:0] e_res;
        bit [2:0]  e_code;
        int        e_stall;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        r_is64, r_we, r_sgn, r_err;
        bit [1:0]  r_size;
        bit [31:0] r_addr;
        bit [63:0] r_wdata, r_rd, r_bwd, r_res;
        bit [7:0]  r_be;
        bit [2:0]  r_code;
        int        r_delay, r_stall;

        vecs[0]  = '{0, 0, 2'd2, 0, 32'h100, 64'h0, 64'hDEADBEEF, 2, 0, 8'h0F, 64'h0, 64'hDEADBEEF, 3'd0, 4};
        vecs[1]  = '{0, 0, 2'd0, 1, 32'h103, 64'h0, 64'h80FF0000, 0, 0, 8'h08, 64'h0, 64'hFFFFFF80, 3'd0, 2};
        vecs[2]  = '{0, 0, 2'd0, 0, 32'h103, 64'h0, 64'h80FF0000, 0, 0, 8'h08, 64'h0, 64'h00000080, 3'd0, 2};
        vecs[3]  = '{0, 1, 2'd1, 0, 32'h102, 64'h1234ABCD, 64'h0, 1, 0, 8'h0C, 64'hABCD0000, 64'h0, 3'd0, 3};
        vecs[4]  = '{0, 0, 2'd1, 0, 32'h101, 64'h0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 3'd1, 1};
        vecs[5]  = '{0, 1, 2'd2, 0, 32'h200, 64'h11223344, 64'h0, 99, 0, 8'h0F, 64'h11223344, 64'h0, 3'd4, 5};
        vecs[6]  = '{0, 0, 2'd2, 0, 32'h104, 64'h0, 64'hCAFEF00D, 1, 1, 8'h0F, 64'h0, 64'h0, 3'd3, 3};
        vecs[7]  = '{0, 0, 2'd3, 0, 32'h0, 64'h0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 3'd5, 1};
        vecs[8]  = '{0, 1, 2'd2, 0, 32'h102, 64'h0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 3'd2, 1};
        vecs[9]  = '{0, 0, 2'd2, 0, 32'h108, 64'h0, 64'h12345678, 3, 0, 8'h0F, 64'h0, 64'h12345678, 3'd0, 5};
        vecs[10] = '{1, 0, 2'd3, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 0, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 3'd0, 2};
        vecs[11] = '{1, 0, 2'd3, 0, 32'h4, 64'h0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 3'd1, 1};
        vecs[12] = '{1, 0, 2'd2, 1, 32'hC, 64'h0, 64'h8000000100000000, 0, 0, 8'hF0, 64'h0, 64'hFFFFFFFF80000001, 3'd0, 2};
        vecs[13] = '{1, 1, 2'd0, 0, 32'hF, 64'hAA, 64'h0, 0, 0, 8'h80, 64'hAA00000000000000, 64'h0, 3'd0, 2};

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; sel64 = 1'b0; ack = 1'b0; err = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            chk($sformatf("reset_outputs_dut%0d", s), {rv_m, ev_m, breq_m, bwe_m, stall_m, ec_m, ben_m},
                64'(0));
            chk($sformatf("reset_data_dut%0d", s), rd_m | bwd_m | 64'(baddr_m), 64'(0));
        end
        sel64 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 14; v++)
            run_txn($sformatf("vec%0d", v), vecs[v].is64, vecs[v].we, vecs[v].size, vecs[v].sgn,
                    vecs[v].addr, vecs[v].wdata, vecs[v].rd, vecs[v].delay, vecs[v].berr,
                    vecs[v].e_be, vecs[v].e_bwd, vecs[v].e_res, vecs[v].e_code, vecs[v].e_stall);

        // Reset asserted while a load is waiting on the bus.
        @(negedge clk);
        sel64 = 1'b0; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h300;
        ack = 1'b0; err = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_req_before", 64'(breq_m), 64'(1));
        chk("rst_busy_stall_before", 64'(stall_m), 64'(1));
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy_req_after", 64'(breq_m), 64'(0));
        chk("rst_busy_flags_after", 64'({stall_m, rv_m, ev_m}), 64'(0));
        reset = 1'b1;
        $display("txn reset_mid_busy dut32 bus_req=%0d stall=%0d", breq_m, stall_m);
        run_txn("post_reset", 0, 0, 2'd2, 0, 32'h300, 64'h0, 64'h5A5A1234, 0, 0,
                8'h0F, 64'h0, 64'h5A5A1234, 3'd0, 2);

        for (int t = 0; t < 80; t++) begin
            r_is64  = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_sgn   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = $urandom & 32'h0000FFFF;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            r_wdata = {$urandom, $urandom};
            r_rd    = {$urandom, $urandom};
            r_err   = ($urandom_range(0, 7) == 0);
            if (r_is64) r_delay = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            else        r_delay = int'($urandom_range(0, 5));
            model(r_is64, r_we, r_size, r_sgn, r_addr, r_wdata, r_rd, r_delay, r_err,
                  r_be, r_bwd, r_res, r_code, r_stall);
            run_txn($sformatf("rnd%0d", t), r_is64, r_we, r_size, r_sgn, r_addr, r_wdata, r_rd,
                    r_delay, r_err, r_be, r_bwd, r_res, r_code, r_stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
